// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC owner and registered instruction queue between the ROM and decode.
// Optional FETCH_PERF_CNT_EN adds Perf_Fetched/Perf_Flushed counters.
module fetch_queue_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  output logic        Instr_Valid,
  input  logic        Instr_Ready,
  output logic [31:0] Instr,
  output logic [31:0] Instr_PC,
  output logic [31:0] Instr_PCPlus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Flushed
`endif
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  logic [31:0] pc;
  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic pop, push;
  assign Imem_Addr = pc;
  assign Instr_Valid = count != '0;
  assign pop = Instr_Valid & Instr_Ready;
  assign push = ~Redirect_Valid & ((count < CW'(QDEPTH)) | pop);
  assign Instr = Instr_Valid ? q_instr[rd_ptr] : '0;
  assign Instr_PC = Instr_Valid ? q_pc[rd_ptr] : '0;
  assign Instr_PCPlus4 = Instr_PC + 32'd4;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (Redirect_Valid) begin
      pc <= {Redirect_PC[31:2], 2'b00};
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      // pointers wrap naturally because QDEPTH is a power of two
      pc <= push ? pc + 32'd4 : pc;
      count <= count + CW'(push) - CW'(pop);
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      q_instr[wr_ptr] <= Imem_Data;
      q_pc[wr_ptr] <= pc;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Perf_Fetched <= '0;
      Perf_Flushed <= '0;
    end else begin
      Perf_Fetched <= push ? Perf_Fetched + 32'd1 : Perf_Fetched;
      Perf_Flushed <= Redirect_Valid ? Perf_Flushed + 32'(count) - 32'(pop) : Perf_Flushed;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed vector table plus hand sequences for wrap, reset priority and perf counters.
module tb_fetch_queue_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rv, rdy, valid;
  logic [31:0] rpc, addr, data, instr, ipc, ipc4;
  logic w_rst_n, w_rv, w_rdy, w_valid;
  logic [31:0] w_rpc, w_addr, w_data, w_instr, w_ipc, w_ipc4;
  assign data = addr >> 2;
  assign w_data = w_addr >> 2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushed, w_pf, w_pl;
`endif
  fetch_queue_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .Imem_Addr(addr), .Imem_Data(data),
    .Redirect_Valid(rv), .Redirect_PC(rpc), .Instr_Valid(valid), .Instr_Ready(rdy),
    .Instr(instr), .Instr_PC(ipc), .Instr_PCPlus4(ipc4)
`ifdef FETCH_PERF_CNT_EN
    , .Perf_Fetched(perf_fetched), .Perf_Flushed(perf_flushed)
`endif
  );
  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .Imem_Addr(w_addr), .Imem_Data(w_data),
    .Redirect_Valid(w_rv), .Redirect_PC(w_rpc), .Instr_Valid(w_valid), .Instr_Ready(w_rdy),
    .Instr(w_instr), .Instr_PC(w_ipc), .Instr_PCPlus4(w_ipc4)
`ifdef FETCH_PERF_CNT_EN
    , .Perf_Fetched(w_pf), .Perf_Flushed(w_pl)
`endif
  );
  typedef struct packed {
    logic rst_n, rv;
    logic [31:0] rpc;
    logic rdy, ev;
    logic [31:0] ei, epc, ea;
  } vec_t;
  vec_t tv[$];
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic v, input logic [31:0] p, input logic y,
                     input logic e, input logic [31:0] i, input logic [31:0] pcv, input logic [31:0] a);
    tv.push_back({r, v, p, y, e, i, pcv, a});
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; rv = 1'b0; rpc = '0; rdy = 1'b1;
    w_rst_n = 1'b0; w_rv = 1'b0; w_rpc = '0; w_rdy = 1'b0;
    tick();
    tick();
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_pc", ipc, 32'd0);
    chk("reset_pcplus4", ipc4, 32'd4);
    chk("reset_addr", addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("reset_perf_fetched", perf_fetched, 32'd0);
    chk("reset_perf_flushed", perf_flushed, 32'd0);
`endif
    // rst_n, redirect, target, ready | valid, instr, pc, addr (state before the edge)
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,   32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,  32'h0,   32'h4);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,  32'h0,   32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,  32'h0,   32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,  32'h0,   32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,  32'h0,   32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h0,   32'h8);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1,  32'h4,   32'hC);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h2,  32'h8,   32'h10);
    add(1'b1, 1'b1, 32'h103, 1'b1, 1'b1, 32'h3,  32'hC,   32'h14);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,  32'h0,   32'h100);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h40, 32'h100, 32'h104);
    add(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'h41, 32'h104, 32'h108);
    add(1'b1, 1'b1, 32'h304, 1'b1, 1'b0, 32'h0,  32'h0,   32'h200);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,   32'h304);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC1, 32'h304, 32'h308);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'hC1, 32'h304, 32'h30C);
    add(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'hC1, 32'h304, 32'h30C);
    add(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,   32'h0);
    add(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,  32'h0,   32'h4);
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n; rv = tv[i].rv; rpc = tv[i].rpc; rdy = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_instr", i), instr, tv[i].ei);
      chk($sformatf("v%0d_pc", i), ipc, tv[i].epc);
      chk($sformatf("v%0d_pcplus4", i), ipc4, tv[i].epc + 32'd4);
      chk($sformatf("v%0d_addr", i), addr, tv[i].ea);
      tick();
    end
    // PC wrap across the top of the address space
    w_rst_n = 1'b1; w_rdy = 1'b1;
    #1;
    chk("wrap_empty_valid", {31'd0, w_valid}, 32'd0);
    chk("wrap_addr", w_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap0_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap0_pc", w_ipc, 32'hFFFF_FFF8);
    chk("wrap0_pcplus4", w_ipc4, 32'hFFFF_FFFC);
    chk("wrap0_instr", w_instr, 32'h3FFF_FFFE);
    tick();
    chk("wrap1_pc", w_ipc, 32'hFFFF_FFFC);
    chk("wrap1_pcplus4", w_ipc4, 32'h0000_0000);
    chk("wrap1_instr", w_instr, 32'h3FFF_FFFF);
    tick();
    chk("wrap2_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap2_pc", w_ipc, 32'h0000_0000);
    chk("wrap2_pcplus4", w_ipc4, 32'h0000_0004);
    chk("wrap2_instr", w_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    rst_n = 1'b0; rv = 1'b0; rdy = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("perf_clear_fetched", perf_fetched, 32'd0);
    repeat (9) tick();
    rdy = 1'b0;
    tick();
    chk("perf_full_valid", {31'd0, valid}, 32'd1);
    rv = 1'b1; rpc = 32'h40;
    tick();
    rv = 1'b0;
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_flushed", perf_flushed, 32'd2);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
